// File: rtl/wb_stage_if.sv
// Memory-stage to write-back handshake plus register-file write port.
// master drives the instruction side; slave is the write-back stage.
interface wb_stage_if;
    logic        MEM_kick_up;
    logic [31:0] ALU_result;
    logic [31:0] Data_mem_read_data;
    logic        Controller_memtoreg;
    logic        Controller_regwrite;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write_enable;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_data;
    logic        WB_kick_up;
    logic        WB_busy;

    modport master (
        output MEM_kick_up, ALU_result, Data_mem_read_data, Controller_memtoreg,
               Controller_regwrite, funct3, rd,
        input  reg_write_enable, reg_write_addr, reg_write_data, WB_kick_up, WB_busy
    );

    modport slave (
        input  MEM_kick_up, ALU_result, Data_mem_read_data, Controller_memtoreg,
               Controller_regwrite, funct3, rd,
        output reg_write_enable, reg_write_addr, reg_write_data, WB_kick_up, WB_busy
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: waits out load latency, extracts load data, performs one
// register-file write and then pulses WB_kick_up so fetch can advance.
module wb_stage #(
    parameter int unsigned LOAD_LATENCY = 1
) (
    input logic       clk,
    input logic       reset,
    wb_stage_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StWait, StWrite} state_e;

    localparam logic [3:0] LatInit = 4'(LOAD_LATENCY);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        regwrite_q, regwrite_d;
    logic [31:0] data_q, data_d;
    logic        kick_q;
    logic [31:0] load_data;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Halves use address bit 1 only; misaligned accesses are silently accepted.
    always_comb begin
        sel_byte = bus.Data_mem_read_data[{addr_lo_q, 3'b000} +: 8];
        sel_half = bus.Data_mem_read_data[{addr_lo_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_data = {24'b0, sel_byte};
            3'b101:  load_data = {16'b0, sel_half};
            default: load_data = bus.Data_mem_read_data;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_lo_d  = addr_lo_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        regwrite_d = regwrite_q;
        data_d     = data_q;
        case (state_q)
            StIdle: begin
                if (bus.MEM_kick_up) begin
                    addr_lo_d  = bus.ALU_result[1:0];
                    rd_d       = bus.rd;
                    funct3_d   = bus.funct3;
                    regwrite_d = bus.Controller_regwrite;
                    if (bus.Controller_memtoreg) begin
                        cnt_d   = LatInit;
                        state_d = StWait;
                    end else begin
                        data_d  = bus.ALU_result;
                        state_d = StWrite;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                // Read word is valid in the last WAIT cycle only.
                if (cnt_q == 4'd1) begin
                    data_d  = load_data;
                    state_d = StWrite;
                end
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            addr_lo_q  <= 2'd0;
            rd_q       <= 5'd0;
            funct3_q   <= 3'd0;
            regwrite_q <= 1'b0;
            data_q     <= 32'd0;
            kick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_lo_q  <= addr_lo_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            regwrite_q <= regwrite_d;
            data_q     <= data_d;
            kick_q     <= (state_q == StWrite);
        end
    end

    assign bus.reg_write_enable = (state_q == StWrite) && regwrite_q && (rd_q != 5'd0);
    assign bus.reg_write_addr   = rd_q;
    assign bus.reg_write_data   = data_q;
    assign bus.WB_kick_up       = kick_q;
    assign bus.WB_busy          = (state_q != StIdle);
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench: two wb_stage instances (latency 1 and 3) share stimulus
// and are compared against an event-timing reference model.
module tb_wb_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_stage_if bus0 ();
    wb_stage_if bus1 ();

    wb_stage #(.LOAD_LATENCY(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    wb_stage #(.LOAD_LATENCY(3)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    typedef struct {
        logic        kick;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        mtr;
        logic        rw;
        logic [2:0]  f3;
        logic [4:0]  rd;
    } stim_t;

    // One outstanding instruction per DUT, described by its accept cycle.
    typedef struct {
        int          ta;
        bit          load;
        bit          rw;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [4:0]  addr_h;
        logic [31:0] data_h;
    } mdl_t;

    mdl_t m[2];
    int   lat[2];
    int   cyc;
    int   total;
    int   bad;

    function automatic logic [31:0] extract(logic [2:0] f3, logic [31:0] addr,
                                            logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> (8 * addr[1:0]));
        h = 16'(word >> (16 * addr[1]));
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b001:  return 32'($signed(h));
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    function automatic int wcyc(int d);
        return m[d].ta + (m[d].load ? lat[d] + 1 : 1);
    endfunction

    function automatic bit busy(int d, int c);
        return m[d].ta >= 0 && c > m[d].ta && c <= wcyc(d);
    endfunction

    // Packed as {busy, we, addr[4:0], data[31:0], kick}.
    function automatic logic [39:0] expv(int d, int c);
        bit          act;
        logic        we;
        logic        kick;
        logic [4:0]  a;
        logic [31:0] dt;
        act  = m[d].ta >= 0;
        we   = act && c == wcyc(d) && m[d].rw && m[d].rd != 5'd0;
        kick = act && c == wcyc(d) + 1;
        a    = (act && c > m[d].ta) ? m[d].rd : m[d].addr_h;
        dt   = (act && c >= wcyc(d)) ? m[d].wdata : m[d].data_h;
        return {busy(d, c), we, a, dt, kick};
    endfunction

    function automatic logic [39:0] obs(int d);
        if (d == 0)
            return {bus0.WB_busy, bus0.reg_write_enable, bus0.reg_write_addr,
                    bus0.reg_write_data, bus0.WB_kick_up};
        return {bus1.WB_busy, bus1.reg_write_enable, bus1.reg_write_addr,
                bus1.reg_write_data, bus1.WB_kick_up};
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.kick  = 1'b0;
        s.alu   = $urandom;
        s.rdata = $urandom;
        s.mtr   = 1'($urandom);
        s.rw    = 1'($urandom);
        s.f3    = 3'($urandom);
        s.rd    = 5'($urandom);
        return s;
    endfunction

    function automatic stim_t mk(logic [31:0] alu, logic mtr, logic rw, logic [2:0] f3,
                                 logic [4:0] rd);
        stim_t s;
        s       = idle();
        s.kick  = 1'b1;
        s.alu   = alu;
        s.mtr   = mtr;
        s.rw    = rw;
        s.f3    = f3;
        s.rd    = rd;
        return s;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m[d].ta     = -1;
            m[d].load   = 1'b0;
            m[d].rw     = 1'b0;
            m[d].rd     = '0;
            m[d].alu    = '0;
            m[d].f3     = '0;
            m[d].wdata  = '0;
            m[d].addr_h = '0;
            m[d].data_h = '0;
        end
    endtask

    task automatic drive(input stim_t s);
        bus0.MEM_kick_up = s.kick;         bus1.MEM_kick_up = s.kick;
        bus0.ALU_result = s.alu;           bus1.ALU_result = s.alu;
        bus0.Data_mem_read_data = s.rdata; bus1.Data_mem_read_data = s.rdata;
        bus0.Controller_memtoreg = s.mtr;  bus1.Controller_memtoreg = s.mtr;
        bus0.Controller_regwrite = s.rw;   bus1.Controller_regwrite = s.rw;
        bus0.funct3 = s.f3;                bus1.funct3 = s.f3;
        bus0.rd = s.rd;                    bus1.rd = s.rd;
    endtask

    // Apply stimulus for the current cycle, advance the model, move to next cycle.
    task automatic cycle(input stim_t s);
        logic [39:0] v;
        drive(s);
        for (int d = 0; d < 2; d++) begin
            if (m[d].ta >= 0 && m[d].load && cyc == m[d].ta + lat[d])
                m[d].wdata = extract(m[d].f3, m[d].alu, s.rdata);
            if (s.kick && !busy(d, cyc)) begin
                v           = expv(d, cyc);
                m[d].addr_h = v[37:33];
                m[d].data_h = v[32:1];
                m[d].ta     = cyc;
                m[d].load   = s.mtr;
                m[d].rw     = s.rw;
                m[d].rd     = s.rd;
                m[d].alu    = s.alu;
                m[d].f3     = s.f3;
                if (!s.mtr) m[d].wdata = s.alu;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        stim_t s;
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (obs(d) !== 40'd0) begin
                bad++;
                $display("FAIL reset_now dut%0d got=%h want=%h", d, obs(d), 40'd0);
            end
        end
        s = mk(32'hFFFF_FFFF, 1'b0, 1'b1, 3'd2, 5'd9);
        drive(s);
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (obs(d) !== 40'd0) begin
                bad++;
                $display("FAIL reset_hold dut%0d got=%h want=%h", d, obs(d), 40'd0);
            end
        end
        drive(idle());
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_add();
        stim_t q[$];
        q = '{mk(32'h0000_1234, 1'b0, 1'b1, 3'd0, 5'd5), idle(), idle()};
        foreach (q[i]) begin
            cycle(q[i]);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs(d) !== expv(d, cyc)) begin
                    bad++;
                    $display("FAIL add_model dut%0d cyc=%0d got=%h want=%h",
                             d, cyc, obs(d), expv(d, cyc));
                end
            end
            total++;
            if (i == 0 && obs(1) !== {1'b1, 1'b1, 5'd5, 32'h0000_1234, 1'b0}) begin
                bad++;
                $display("FAIL add_write got=%h", obs(1));
            end else if (i == 1 && obs(1) !== {1'b0, 1'b0, 5'd5, 32'h0000_1234, 1'b1}) begin
                bad++;
                $display("FAIL add_kick got=%h", obs(1));
            end else if (i == 2 && obs(1) !== {1'b0, 1'b0, 5'd5, 32'h0000_1234, 1'b0}) begin
                bad++;
                $display("FAIL add_idle got=%h", obs(1));
            end
        end
    endtask

    task automatic test_lb(input logic [2:0] f3, input logic [31:0] want);
        stim_t q[$];
        q = '{mk(32'h0000_0003, 1'b1, 1'b1, f3, 5'd7), idle(), idle(), idle(), idle(), idle()};
        q[1].rdata = 32'h80FF_7F01;
        foreach (q[i]) begin
            cycle(q[i]);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs(d) !== expv(d, cyc)) begin
                    bad++;
                    $display("FAIL lb_model f3=%0d dut%0d cyc=%0d got=%h want=%h",
                             f3, d, cyc, obs(d), expv(d, cyc));
                end
            end
            if (i == 1 || i == 2) begin
                total++;
                if (obs(0) !== {i == 1, i == 1, 5'd7, want, i == 2}) begin
                    bad++;
                    $display("FAIL lb_l1 f3=%0d step=%0d got=%h data_want=%h",
                             f3, i, obs(0), want);
                end
            end
        end
    endtask

    task automatic test_lh(input logic [2:0] f3, input logic [31:0] want);
        stim_t q[$];
        q = '{mk(32'h0000_0002, 1'b1, 1'b1, f3, 5'd9), idle(), idle(), idle(), idle(), idle(),
              idle()};
        q[3].rdata = 32'hBEEF_1234;
        foreach (q[i]) begin
            cycle(q[i]);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs(d) !== expv(d, cyc)) begin
                    bad++;
                    $display("FAIL lh_model f3=%0d dut%0d cyc=%0d got=%h want=%h",
                             f3, d, cyc, obs(d), expv(d, cyc));
                end
            end
            if (i == 3 || i == 4) begin
                total++;
                if (obs(1) !== {i == 3, i == 3, 5'd9, want, i == 4}) begin
                    bad++;
                    $display("FAIL lh_l3 f3=%0d step=%0d got=%h data_want=%h",
                             f3, i, obs(1), want);
                end
            end
        end
    endtask

    task automatic test_no_write();
        stim_t q[$];
        int    we_cnt[2];
        int    kick_cnt[2];
        logic [39:0] v;
        q = {};
        q.push_back(mk($urandom, 1'b0, 1'b1, 3'd0, 5'd0));
        repeat (5) q.push_back(idle());
        q.push_back(mk($urandom, 1'b0, 1'b0, 3'd2, 5'd12));
        repeat (5) q.push_back(idle());
        q.push_back(mk($urandom, 1'b1, 1'b0, 3'd2, 5'd13));
        repeat (5) q.push_back(idle());
        we_cnt   = '{0, 0};
        kick_cnt = '{0, 0};
        foreach (q[i]) begin
            cycle(q[i]);
            for (int d = 0; d < 2; d++) begin
                v = obs(d);
                we_cnt[d]   += int'(v[38]);
                kick_cnt[d] += int'(v[0]);
                total++;
                if (v !== expv(d, cyc)) begin
                    bad++;
                    $display("FAIL nowrite_model dut%0d cyc=%0d got=%h want=%h",
                             d, cyc, v, expv(d, cyc));
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            total++;
            if (we_cnt[d] !== 0 || kick_cnt[d] !== 3) begin
                bad++;
                $display("FAIL nowrite_count dut%0d writes=%0d kicks=%0d want 0/3",
                         d, we_cnt[d], kick_cnt[d]);
            end
        end
    endtask

    task automatic test_ignore();
        stim_t q[$];
        int    we_cnt[2];
        int    kick_cnt[2];
        logic [39:0] v;
        q = '{mk(32'h0000_0100, 1'b1, 1'b1, 3'd2, 5'd3), mk(32'h44, 1'b0, 1'b1, 3'd0, 5'd4),
              mk(32'h66, 1'b0, 1'b1, 3'd0, 5'd6), idle(), idle(), idle(), idle(), idle()};
        we_cnt   = '{0, 0};
        kick_cnt = '{0, 0};
        foreach (q[i]) begin
            cycle(q[i]);
            for (int d = 0; d < 2; d++) begin
                v = obs(d);
                we_cnt[d]   += int'(v[38]);
                kick_cnt[d] += int'(v[0]);
                total++;
                if (v !== expv(d, cyc)) begin
                    bad++;
                    $display("FAIL ignore_model dut%0d cyc=%0d got=%h want=%h",
                             d, cyc, v, expv(d, cyc));
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            total++;
            if (we_cnt[d] !== 1 || kick_cnt[d] !== 1) begin
                bad++;
                $display("FAIL ignore_count dut%0d writes=%0d kicks=%0d want 1/1",
                         d, we_cnt[d], kick_cnt[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t q[$];
        q = '{mk(32'hA, 1'b0, 1'b1, 3'd0, 5'd10), idle(), mk(32'hB, 1'b0, 1'b1, 3'd0, 5'd11),
              idle(), idle()};
        foreach (q[i]) begin
            cycle(q[i]);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs(d) !== expv(d, cyc)) begin
                    bad++;
                    $display("FAIL b2b_model dut%0d cyc=%0d got=%h want=%h",
                             d, cyc, obs(d), expv(d, cyc));
                end
            end
            if (i == 2) begin
                total++;
                if (obs(0) !== {1'b1, 1'b1, 5'd11, 32'hB, 1'b0}) begin
                    bad++;
                    $display("FAIL b2b_second got=%h", obs(0));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [39:0] v;
        cycle(mk(32'h0000_0200, 1'b1, 1'b1, 3'd2, 5'd14));
        cycle(idle());
        reset = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (obs(d) !== 40'd0) begin
                bad++;
                $display("FAIL reset_mid dut%0d got=%h want=%h", d, obs(d), 40'd0);
            end
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc += 2;
        repeat (6) begin
            cycle(idle());
            for (int d = 0; d < 2; d++) begin
                v = obs(d);
                total++;
                if (v !== 40'd0 || v !== expv(d, cyc)) begin
                    bad++;
                    $display("FAIL reset_after dut%0d cyc=%0d got=%h want=%h",
                             d, cyc, v, expv(d, cyc));
                end
            end
        end
        test_add();
    endtask

    task automatic test_random();
        stim_t s;
        for (int n = 0; n < 400; n++) begin
            s = idle();
            s.kick = ($urandom_range(0, 2) == 0);
            cycle(s);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs(d) !== expv(d, cyc)) begin
                    bad++;
                    $display("FAIL random dut%0d cyc=%0d got=%h want=%h",
                             d, cyc, obs(d), expv(d, cyc));
                end
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        cyc    = 0;
        lat[0] = 1;
        lat[1] = 3;
        model_reset();
        drive(idle());
        reset = 1'b1;
        #2;
        reset = 1'b0;
        test_reset();
        test_add();
        test_lb(3'b000, 32'hFFFF_FF80);
        test_lb(3'b100, 32'h0000_0080);
        test_lh(3'b101, 32'h0000_BEEF);
        test_lh(3'b001, 32'hFFFF_BEEF);
        test_no_write();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Write-back stage of the multi-cycle core, directly downstream of the memory stage. It is triggered by the memory stage's one-cycle done pulse and waits out the data-memory read latency for loads. It extracts and sign- or zero-extends load data, then performs a single register-file write. It finishes by issuing a one-cycle WB_kick_up pulse that lets fetch advance the PC.

Parameters:
LOAD_LATENCY, 1, cycles from MEM_kick_up until Data_mem_read_data is valid; legal range 1..15; 4-bit counter.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
MEM_kick_up  in  1  one-cycle pulse from memory stage: instruction ready for write-back
ALU_result  in  32  ALU result / memory address, valid with MEM_kick_up
Data_mem_read_data  in  32  data-memory read word, valid LOAD_LATENCY cycles after MEM_kick_up
Controller_memtoreg  in  1  1 = load (write memory data), 0 = write ALU_result
Controller_regwrite  in  1  instruction writes rd
funct3  in  3  load width/sign select
rd  in  5  destination register
reg_write_enable  out  1  register-file write strobe
reg_write_addr  out  5  register-file write index
reg_write_data  out  32  register-file write data
WB_kick_up  out  1  one-cycle done pulse to fetch
WB_busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (reset low, asynchronous): state IDLE, counter 0, all captured registers 0, all outputs 0. Reset mid-operation aborts the instruction: no write, no WB_kick_up.
- FSM states: IDLE, WAIT, WRITE.
  - IDLE: when MEM_kick_up=1 at a clock edge, capture ALU_result, rd, funct3, memtoreg and regwrite. If memtoreg=1, go to WAIT and load the counter with LOAD_LATENCY. Otherwise set data_q=ALU_result and go to WRITE.
  - WAIT: decrement the counter each cycle. When the counter equals 1, sample Data_mem_read_data through the extractor into data_q and go to WRITE. WAIT therefore lasts exactly LOAD_LATENCY cycles.
  - WRITE: reg_write_enable = regwrite_q AND (rd_q != 0); Moore output, exactly one cycle. Next state is IDLE. WB_kick_up is registered high at this edge.
- Timing, with MEM_kick_up sampled in cycle T:
  - Non-load: WRITE in T+1, WB_kick_up in T+2.
  - Load: WAIT in T+1..T+L, WRITE in T+L+1, WB_kick_up in T+L+2.
- WB_kick_up: high for exactly one cycle after every accepted instruction. This includes rd=0, regwrite=0 (stores, branches), and memtoreg=1 with regwrite=0.
- reg_write_addr = rd_q and reg_write_data = data_q; both hold between instructions.
- MEM_kick_up while not IDLE (WAIT or WRITE) is ignored. Its coincidence with the WB_kick_up cycle is accepted, because the state is IDLE then.
- Load extraction, with byte select = captured ALU_result[1:0] and half select = ALU_result[1]. Bit 0 is ignored for halves; misaligned addresses raise no fault.
  - 000 LB: sign-extend the selected byte.
  - 001 LH: sign-extend the selected half.
  - 010 LW: full word.
  - 100 LBU: zero-extend the selected byte.
  - 101 LHU: zero-extend the selected half.
  - 011/110/111: full word, unchanged.
- No combinational path from any input to any output.

Test Plan:
- ADD: ALU_result=0x00001234, rd=5, regwrite=1, memtoreg=0, MEM_kick_up at T -> reg_write_enable=1, addr=5, data=0x00001234 in T+1 only; WB_kick_up in T+2 only; WB_busy high in T+1.
- LB, LOAD_LATENCY=1: addr 0x00000003, read data 0x80FF7F01 -> write data 0xFFFFFF80 in T+2; WB_kick_up in T+3. Same stimulus with LBU -> 0x00000080.
- LHU, LOAD_LATENCY=3: addr 0x00000002, read data 0xBEEF1234 valid in T+3 only -> write data 0x0000BEEF in T+4; WB_kick_up in T+5. LH with the same data -> 0xFFFFBEEF.
- rd=0, regwrite=1: reg_write_enable stays 0 throughout; WB_kick_up still pulses in T+2. Store (regwrite=0): same result.
- Second MEM_kick_up during WAIT -> ignored; exactly one write and one WB_kick_up occur. Back-to-back: a new MEM_kick_up in the WB_kick_up cycle is accepted.
- reset driven low in the second WAIT cycle -> outputs 0 immediately, state IDLE, no write and no WB_kick_up afterwards. After reset release, a fresh ADD completes per the first scenario.
